// File: rtl/writeback_seq.sv
// writeback_seq: retires a four-slot execute result bundle one slot per cycle
// into the register file, segment file or store port, then commits the
// bundle's flags and, on a mispredicted branch, pulses a one-cycle flush.
module writeback_seq #(
   parameter int DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DATA_W-1:0]   res_data,
   input  logic [127:0]          res_dest,
   input  logic [3:0]            res_wb,
   input  logic [3:0]            res_is_reg,
   input  logic [3:0]            res_is_seg,
   input  logic [3:0]            res_is_mem,
   input  logic [1:0]            ressize,
   input  logic [17:0]           eflags_in,
   input  logic                  BR_valid_in,
   input  logic                  BR_taken_in,
   input  logic                  BR_correct_in,
   input  logic [31:0]           BR_FIP_in,
   input  logic [31:0]           BR_FIP_p1_in,
   output logic                  reg_we,
   output logic [31:0]           reg_dest,
   output logic [DATA_W-1:0]     reg_data,
   output logic [1:0]            reg_size,
   output logic                  seg_we,
   output logic [31:0]           seg_dest,
   output logic [15:0]           seg_data,
   output logic                  mem_req,
   input  logic                  mem_ready,
   output logic [31:0]           mem_addr,
   output logic [DATA_W-1:0]     mem_data,
   output logic [1:0]            mem_size,
   output logic [17:0]           eflags_out,
   output logic                  flush,
   output logic [31:0]           redirect_eip,
   output logic                  busy
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   logic [0:0]              state_q, state_d;
   logic [3:0]              pend_q, pend_d;
   logic                    zero_q, zero_d;
   logic [3:0][DATA_W-1:0]  data_q;
   logic [3:0][31:0]        dest_q;
   logic [3:0]              isreg_q, isseg_q, ismem_q;
   logic [1:0]              size_q;
   logic [17:0]             flags_q;
   logic [17:0]             eflags_q, eflags_d;
   logic                    brv_q, brt_q, brc_q;
   logic [31:0]             fip_q, fip1_q;
   logic [31:0]             redir_q, redir_d;

   logic                    accept;
   logic [1:0]              sel_idx;
   logic [3:0]              sel_oh;
   logic                    drain;
   logic                    sel_mem, sel_seg, sel_reg;
   logic                    slot_done, last, fin;
   logic [31:0]             tgt;

   assign in_ready = (state_q == S_IDLE);
   assign busy     = ~in_ready;
   assign accept   = in_valid & in_ready;

   // Pick the lowest-index pending slot so paired writes retire in order.
   always_comb begin
      sel_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (pend_q[i]) sel_idx = 2'(i);
   end

   assign sel_oh  = 4'(1) << sel_idx;
   assign drain   = (state_q == S_DRAIN) && (pend_q != 4'd0);

   // Class priority: a store wins over a segment write, which wins over a GPR write.
   assign sel_mem = drain & ismem_q[sel_idx];
   assign sel_seg = drain & ~ismem_q[sel_idx] & isseg_q[sel_idx];
   assign sel_reg = drain & ~ismem_q[sel_idx] & ~isseg_q[sel_idx] & isreg_q[sel_idx];

   // A store slot only retires on the handshake; every other slot takes one cycle.
   assign slot_done = drain & (~sel_mem | mem_ready);
   assign last      = slot_done & ((pend_q & ~sel_oh) == 4'd0);
   // Zero-mask bundles complete in the cycle after acceptance.
   assign fin       = last | zero_q;

   assign tgt          = brt_q ? fip_q : fip1_q;
   assign flush        = fin & brv_q & ~brc_q;
   assign redirect_eip = flush ? tgt : redir_q;
   assign eflags_out   = eflags_q;

   assign reg_we   = sel_reg;
   assign reg_dest = dest_q[sel_idx];
   assign reg_data = data_q[sel_idx];
   assign reg_size = size_q;
   assign seg_we   = sel_seg;
   assign seg_dest = dest_q[sel_idx];
   assign seg_data = data_q[sel_idx][15:0];
   assign mem_req  = sel_mem;
   assign mem_addr = dest_q[sel_idx];
   assign mem_data = data_q[sel_idx];
   assign mem_size = size_q;

   // Next-state for the sequencer, pending mask and commit registers.
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      zero_d   = 1'b0;
      eflags_d = fin ? flags_q : eflags_q;
      redir_d  = flush ? tgt : redir_q;
      if (slot_done) pend_d = pend_q & ~sel_oh;
      if (last)      state_d = S_IDLE;
      if (accept) begin
         pend_d  = res_wb;
         zero_d  = (res_wb == 4'd0);
         state_d = (res_wb != 4'd0) ? S_DRAIN : S_IDLE;
      end
   end

   // Sequencer and commit state; reset discards any in-flight bundle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pend_q   <= 4'd0;
         zero_q   <= 1'b0;
         eflags_q <= 18'h00002;
         redir_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         zero_q   <= zero_d;
         eflags_q <= eflags_d;
         redir_q  <= redir_d;
      end
   end

   // Bundle capture on acceptance; cleared on reset so data outputs read zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         dest_q  <= '0;
         isreg_q <= 4'd0;
         isseg_q <= 4'd0;
         ismem_q <= 4'd0;
         size_q  <= 2'd0;
         flags_q <= 18'd0;
         brv_q   <= 1'b0;
         brt_q   <= 1'b0;
         brc_q   <= 1'b0;
         fip_q   <= 32'd0;
         fip1_q  <= 32'd0;
      end else if (accept) begin
         data_q  <= res_data;
         dest_q  <= res_dest;
         isreg_q <= res_is_reg;
         isseg_q <= res_is_seg;
         ismem_q <= res_is_mem;
         size_q  <= ressize;
         flags_q <= eflags_in;
         brv_q   <= BR_valid_in;
         brt_q   <= BR_taken_in;
         brc_q   <= BR_correct_in;
         fip_q   <= BR_FIP_in;
         fip1_q  <= BR_FIP_p1_in;
      end
   end

endmodule

// File: tb/tb_writeback_seq.sv
// tb_writeback_seq: directed table, reset corner cases and randomized bundles
// checked against a slot-list reference model.
module tb_writeback_seq;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready;
   logic [4*DW-1:0] res_data;
   logic [127:0]    res_dest;
   logic [3:0]      res_wb, res_is_reg, res_is_seg, res_is_mem;
   logic [1:0]      ressize;
   logic [17:0]     eflags_in;
   logic            BR_valid_in, BR_taken_in, BR_correct_in;
   logic [31:0]     BR_FIP_in, BR_FIP_p1_in;
   logic            reg_we, seg_we, mem_req, mem_ready, flush, busy;
   logic [31:0]     reg_dest, seg_dest, mem_addr, redirect_eip;
   logic [DW-1:0]   reg_data, mem_data;
   logic [15:0]     seg_data;
   logic [1:0]      reg_size, mem_size;
   logic [17:0]     eflags_out;

   writeback_seq #(.DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .res_data(res_data), .res_dest(res_dest), .res_wb(res_wb),
      .res_is_reg(res_is_reg), .res_is_seg(res_is_seg), .res_is_mem(res_is_mem),
      .ressize(ressize), .eflags_in(eflags_in), .BR_valid_in(BR_valid_in),
      .BR_taken_in(BR_taken_in), .BR_correct_in(BR_correct_in),
      .BR_FIP_in(BR_FIP_in), .BR_FIP_p1_in(BR_FIP_p1_in),
      .reg_we(reg_we), .reg_dest(reg_dest), .reg_data(reg_data), .reg_size(reg_size),
      .seg_we(seg_we), .seg_dest(seg_dest), .seg_data(seg_data),
      .mem_req(mem_req), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_size(mem_size), .eflags_out(eflags_out),
      .flush(flush), .redirect_eip(redirect_eip), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // current bundle
   logic [63:0] bd [4];
   logic [31:0] bdst [4];
   logic [3:0]  wb, isr, iss, ism;
   logic [1:0]  sz;
   logic [17:0] fl;
   bit          brv, brt, brc;
   logic [31:0] fip, fip1;
   int          stall;
   logic [31:0] exp_redir;

   // one expected cycle: which strobe, flush, and which slot feeds the data
   typedef struct { bit rw; bit sw; bit mr; bit fl; int slot; } cyc_t;
   cyc_t expq[$];

   typedef struct {
      logic [3:0] wb, isr, iss, ism;
      bit brv, brt, brc;
      int stall;
      int len;
      logic [11:0][3:0] seq;   // per cycle {kind, slot}; kind 0 none,1 reg,2 seg,3 mem
      bit efl;
   } vec_t;
   vec_t tbl [7];

   task automatic push_kind(input int kind, input int slot);
      cyc_t c;
      c.rw = (kind == 1); c.sw = (kind == 2); c.mr = (kind == 3);
      c.fl = 1'b0; c.slot = slot;
      expq.push_back(c);
   endtask

   task automatic rand_payload();
      for (int i = 0; i < 4; i++) begin
         bd[i]   = {$urandom, $urandom};
         bdst[i] = $urandom;
      end
      sz = 2'($urandom);
      fl = 18'($urandom);
   endtask

   // Reference model: walk slots 1..4, each enabled slot costs one cycle,
   // a store costs stall+1; the final cycle carries the flush.
   task automatic build_model();
      expq.delete();
      if (wb == 4'd0) push_kind(0, 0);
      else begin
         for (int i = 0; i < 4; i++) begin
            if (wb[i]) begin
               if (ism[i]) begin
                  for (int s = 0; s <= stall; s++) push_kind(3, i);
               end
               else if (iss[i]) push_kind(2, i);
               else if (isr[i]) push_kind(1, i);
               else push_kind(0, i);
            end
         end
      end
      expq[expq.size()-1].fl = brv & ~brc;
   endtask

   // Entered at posedge+1 with the DUT idle; ends at posedge+1 idle again.
   task automatic run_bundle(input string tag);
      int cnt;
      int s;
      res_data = {bd[3], bd[2], bd[1], bd[0]};
      res_dest = {bdst[3], bdst[2], bdst[1], bdst[0]};
      res_wb = wb; res_is_reg = isr; res_is_seg = iss; res_is_mem = ism;
      ressize = sz; eflags_in = fl;
      BR_valid_in = brv; BR_taken_in = brt; BR_correct_in = brc;
      BR_FIP_in = fip; BR_FIP_p1_in = fip1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 0;
      for (int k = 0; k < expq.size(); k++) begin
         if (mem_req) begin
            mem_ready = (cnt >= stall);
            cnt = mem_ready ? 0 : cnt + 1;
         end else begin
            mem_ready = 1'b0;
            cnt = 0;
         end
         @(negedge clk);
         s = expq[k].slot;
         chk($sformatf("%s c%0d strobes{reg,seg,mem,flush}", tag, k),
             {reg_we, seg_we, mem_req, flush},
             {expq[k].rw, expq[k].sw, expq[k].mr, expq[k].fl});
         chk($sformatf("%s c%0d in_ready", tag, k), in_ready, wb == 4'd0);
         chk($sformatf("%s c%0d busy", tag, k), busy, wb != 4'd0);
         if (expq[k].rw) begin
            chk($sformatf("%s c%0d reg_dest", tag, k), reg_dest, bdst[s]);
            chk($sformatf("%s c%0d reg_data", tag, k), reg_data, bd[s]);
            chk($sformatf("%s c%0d reg_size", tag, k), reg_size, sz);
         end
         if (expq[k].sw) begin
            chk($sformatf("%s c%0d seg_dest", tag, k), seg_dest, bdst[s]);
            chk($sformatf("%s c%0d seg_data", tag, k), seg_data, bd[s][15:0]);
         end
         if (expq[k].mr) begin
            chk($sformatf("%s c%0d mem_addr", tag, k), mem_addr, bdst[s]);
            chk($sformatf("%s c%0d mem_data", tag, k), mem_data, bd[s]);
            chk($sformatf("%s c%0d mem_size", tag, k), mem_size, sz);
         end
         if (expq[k].fl) exp_redir = brt ? fip : fip1;
         chk($sformatf("%s c%0d redirect_eip", tag, k), redirect_eip, exp_redir);
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      @(negedge clk);
      chk({tag, " done in_ready"}, in_ready, 1'b1);
      chk({tag, " done strobes"}, {reg_we, seg_we, mem_req, flush}, 4'b0000);
      chk({tag, " done eflags_out"}, eflags_out, fl);
      chk({tag, " done redirect_eip held"}, redirect_eip, exp_redir);
      @(posedge clk); #1;
   endtask

   initial begin
      tbl[0] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 0, 2, 48'h64, 0};
      tbl[1] = '{4'b0110, 4'b0100, 4'b0000, 4'b0010, 0, 0, 0, 3, 5, 48'h6DDDD, 0};
      tbl[2] = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 1, 1, 0, 0, 2, 48'h54, 1};
      tbl[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 48'h0, 1};
      tbl[4] = '{4'b0011, 4'b0001, 4'b0000, 4'b0001, 0, 0, 0, 0, 2, 48'h1C, 0};
      tbl[5] = '{4'b1111, 4'b1111, 4'b1010, 4'b0100, 1, 0, 1, 1, 5, 48'hBEE94, 0};
      tbl[6] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 1, 0, 0, 0, 1, 48'hB, 1};

      rst = 1'b1; in_valid = 1'b0; mem_ready = 1'b0;
      res_data = '0; res_dest = '0; res_wb = '0; res_is_reg = '0;
      res_is_seg = '0; res_is_mem = '0; ressize = '0; eflags_in = '0;
      BR_valid_in = 0; BR_taken_in = 0; BR_correct_in = 0;
      BR_FIP_in = '0; BR_FIP_p1_in = '0;
      exp_redir = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset strobes", {reg_we, seg_we, mem_req, flush}, 4'b0000);
      chk("reset in_ready", in_ready, 1'b1);
      chk("reset eflags_out", eflags_out, 18'h00002);
      chk("reset redirect_eip", redirect_eip, 32'd0);
      chk("reset reg_data", reg_data, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // directed table
      for (int t = 0; t < 7; t++) begin
         wb = tbl[t].wb; isr = tbl[t].isr; iss = tbl[t].iss; ism = tbl[t].ism;
         brv = tbl[t].brv; brt = tbl[t].brt; brc = tbl[t].brc;
         stall = tbl[t].stall;
         fip = 32'h0000_1040; fip1 = 32'h0000_2005;
         rand_payload();
         expq.delete();
         for (int k = 0; k < tbl[t].len; k++) begin
            logic [3:0] nib;
            nib = tbl[t].seq[k];
            push_kind(int'(nib[3:2]), int'(nib[1:0]));
         end
         expq[expq.size()-1].fl = tbl[t].efl;
         run_bundle($sformatf("tbl%0d", t));
         if (t == 2) chk("tbl2 redirect taken", redirect_eip, 32'h0000_1040);
         if (t == 3) chk("tbl3 redirect not-taken", redirect_eip, 32'h0000_2005);
      end

      // reset during a store stall: outputs drop at once, nothing follows
      wb = 4'b0110; isr = 4'b0100; iss = 4'b0000; ism = 4'b0010;
      brv = 1; brt = 1; brc = 0; fip = 32'h0000_3000; fip1 = 32'h0000_3004;
      rand_payload();
      res_data = {bd[3], bd[2], bd[1], bd[0]};
      res_dest = {bdst[3], bdst[2], bdst[1], bdst[0]};
      res_wb = wb; res_is_reg = isr; res_is_seg = iss; res_is_mem = ism;
      ressize = sz; eflags_in = fl;
      BR_valid_in = brv; BR_taken_in = brt; BR_correct_in = brc;
      BR_FIP_in = fip; BR_FIP_p1_in = fip1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall mem_req", mem_req, 1'b1);
      chk("stall mem_addr", mem_addr, bdst[1]);
      #2 rst = 1'b1;
      #1;
      chk("async rst strobes", {reg_we, seg_we, mem_req, flush}, 4'b0000);
      chk("async rst in_ready", in_ready, 1'b1);
      chk("async rst eflags_out", eflags_out, 18'h00002);
      chk("async rst redirect_eip", redirect_eip, 32'd0);
      chk("async rst mem_addr", mem_addr, 32'd0);
      chk("async rst mem_data", mem_data, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; mem_ready = 1'b1; exp_redir = 32'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("post-rst c%0d strobes", k), {reg_we, seg_we, mem_req, flush}, 4'b0000);
         chk($sformatf("post-rst c%0d in_ready", k), in_ready, 1'b1);
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;

      // randomized bundles against the reference model
      for (int r = 0; r < 40; r++) begin
         wb = 4'($urandom); isr = 4'($urandom); iss = 4'($urandom); ism = 4'($urandom);
         brv = 1'($urandom); brt = 1'($urandom); brc = 1'($urandom);
         fip = $urandom; fip1 = $urandom;
         stall = $urandom_range(0, 2);
         rand_payload();
         build_model();
         run_bundle($sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/writeback_seq.md
WRITEBACK_SEQ -- requirements
Module: writeback_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 64, giving the width of one result slot.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, the execute stage presents a result bundle.
REQ-005 SHALL have port in_ready, output, 1, the bundle is accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port res_data, input, 4*DATA_W, slots res1..res4 with res1 in the LSBs.
REQ-007 SHALL have port res_dest, input, 128, four 32-bit destinations, slot order as res_data.
REQ-008 SHALL have ports res_wb, res_is_reg, res_is_seg and res_is_mem, each input, 4, per-slot write enable and target class, bit i = slot i+1.
REQ-009 SHALL have port ressize, input, 2, the operand size for all slots.
REQ-010 SHALL have port eflags_in, input, 18, the flags produced by the bundle.
REQ-011 SHALL have ports BR_valid_in, BR_taken_in and BR_correct_in, each input, 1, plus BR_FIP_in and BR_FIP_p1_in, each input, 32: the branch resolution.
REQ-012 SHALL have reg_we (output, 1), reg_dest (output, 32), reg_data (output, DATA_W) and reg_size (output, 2), the register-file write port.
REQ-013 SHALL have seg_we (output, 1), seg_dest (output, 32) and seg_data (output, 16), the segment-file write port.
REQ-014 SHALL have mem_req (output, 1), mem_ready (input, 1), mem_addr (output, 32), mem_data (output, DATA_W) and mem_size (output, 2), the store port.
REQ-015 SHALL have eflags_out, output, 18, the architectural flags.
REQ-016 SHALL have flush (output, 1), redirect_eip (output, 32) and busy (output, 1).

Function
REQ-017 SHALL implement two states: IDLE and DRAIN.
REQ-018 SHALL drive in_ready = 1 in IDLE and 0 in DRAIN; busy SHALL equal the inverse of in_ready.
REQ-019 On acceptance, SHALL latch every input bundle field and load the pending mask from res_wb.
- Mask nonzero: go to DRAIN.
- Mask zero: stay in IDLE; the bundle completes on the next cycle.
REQ-020 In DRAIN, SHALL select exactly one slot per cycle: the lowest-index pending slot. Strict res1-to-res4 order is required so that an XCHG pair retires in order.
REQ-021 Class priority for the selected slot: is_mem over is_seg over is_reg; the lower-priority flags SHALL be ignored.
REQ-022 Reg slot: reg_we = 1 for one cycle with the latched dest, data and size; the pending bit clears the same cycle.
REQ-023 Seg slot: seg_we = 1 for one cycle; seg_data = data[15:0]; the pending bit clears.
REQ-024 Mem slot: mem_req SHALL stay high with stable addr, data and size until a cycle with mem_ready = 1; the pending bit clears on that cycle. The sequence SHALL NOT advance while mem_ready = 0.
REQ-025 Slot with wb = 1 and no class flag: SHALL be dropped in one cycle with no write strobe.
REQ-026 The final cycle is the one in which the last pending bit clears.
- eflags_out SHALL load the latched flags at the end of that cycle.
- The FSM SHALL return to IDLE.
REQ-027 A zero-mask bundle SHALL load eflags_out and perform its flush duty in the cycle after acceptance.
REQ-028 If the latched BR_valid = 1 and BR_correct = 0, flush SHALL pulse for exactly one cycle, coincident with the final cycle (REQ-026) or the REQ-027 cycle. redirect_eip = BR_taken ? BR_FIP : BR_FIP_p1.
REQ-029 flush = 0 when BR_valid = 0 or BR_correct = 1; redirect_eip SHALL hold its last value when flush = 0.
REQ-030 Latency: first write strobe at acceptance+1; a bundle of k non-mem slots completes at acceptance+k.
REQ-031 Strobes SHALL be mutually exclusive: at most one of reg_we, seg_we and mem_req is high per cycle.

Reset
REQ-032 While rst = 1, the block SHALL force:
- state IDLE, pending mask 0;
- reg_we, seg_we, mem_req and flush = 0;
- eflags_out = 18'h00002, redirect_eip = 0;
- all data/address outputs = 0, in_ready = 1.
REQ-033 Reset asserted mid-DRAIN SHALL discard the remaining slots and any pending flush, with no partial strobe after reset.

Verification
REQ-034 Accept res_wb=0101, res_is_reg=0101 -> reg_we at T+1 (slot1 dest/data) and at T+2 (slot3); eflags_out updates after T+2; in_ready is 0 during T+1..T+2.
REQ-035 Slot2 mem with mem_ready held low for 3 cycles -> mem_req is held 4 cycles with stable mem_addr = res_dest[63:32]; slot3 waits and writes only after mem_ready.
REQ-036 BR_valid=1, BR_correct=0, BR_taken=1, BR_FIP=32'h0000_1040, two reg slots -> a single flush pulse at T+2 with redirect_eip = 32'h0000_1040.
REQ-037 res_wb=0000, BR_valid=1, BR_correct=0, BR_taken=0, BR_FIP_p1=32'h0000_2005 -> flush at T+1 with redirect_eip = 32'h0000_2005; FSM stays IDLE.
REQ-038 Slot with is_mem=1 and is_reg=1 -> only mem_req is asserted; slot with wb=1 and no class -> one cycle, no strobe.
REQ-039 Assert rst during the mem stall of REQ-035 -> all outputs are at their reset values immediately (asynchronously); no later strobe or flush.
